fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core, directly upstream of the IF/ID register.
- Owns the word-addressed PC and drives a variable-latency instruction memory through a req/ready handshake.
- Holds a fetched instruction across hazard stalls and applies branch/jump redirects.
- Presents the instruction, PC+1 and a flush request to the IF/ID register.

Parameters:
- ADDR_W, 30, word-address width of the PC (byte address = {pc, 2'b00}).
- RESET_PC, 30'h0000_0000, PC loaded on reset.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_stall  in  1  hazard hold; the same signal drives the IF/ID register's write-hold.
- i_branch_taken  in  1  branch resolved taken in decode.
- i_branch_target  in  ADDR_W  branch target word address.
- i_jump  in  1  jump in decode.
- i_jump_target  in  ADDR_W  jump target word address.
- o_imem_req  out  1  instruction memory request.
- o_imem_addr  out  ADDR_W  memory word address, equal to the PC.
- i_imem_ready  in  1  memory data valid for o_imem_addr in this cycle.
- i_imem_rdata  in  32  instruction word.
- o_instruct_dataF  out  32  instruction to the IF/ID register.
- o_add_pc  out  ADDR_W  PC+1 to the IF/ID register.
- o_valid  out  1  o_instruct_dataF holds a real instruction.
- o_clearD  out  1  flush request to the IF/ID register clear input.

Behaviour:
- State register values: S_IDLE, S_REQ, S_HOLD.
- Registers: pc, hold_buf[31:0].

Reset (i_rst_n=0 at an edge, including mid-request or in S_HOLD):
- pc=RESET_PC, state=S_IDLE, hold_buf=0.
- Outputs while in S_IDLE: o_imem_req=0, o_valid=0, o_instruct_dataF=0, o_clearD=1, o_imem_addr=RESET_PC, o_add_pc=RESET_PC+1.

State transitions:
- S_IDLE: always -> S_REQ next cycle (one bubble after reset).
- S_REQ:
  - o_imem_req=1 and o_imem_addr=pc, held stable until ready or redirect.
  - When i_imem_ready=1: o_valid=1 and o_instruct_dataF=i_imem_rdata, combinational in the same cycle.
  - ready & ~i_stall: pc <= pc+1, stay in S_REQ (back-to-back fetch, 1 instr/cycle with zero-wait memory).
  - ready & i_stall: hold_buf <= i_imem_rdata, -> S_HOLD, pc unchanged.
  - ~ready: o_valid=0, stay in S_REQ.
- S_HOLD:
  - o_imem_req=0, o_valid=1, o_instruct_dataF=hold_buf.
  - ~i_stall: pc <= pc+1, -> S_REQ.
  - i_stall: remain in S_HOLD.

Redirect (redirect = i_branch_taken | i_jump):
- Priority over stall, hold and pending request.
- pc <= i_branch_taken ? i_branch_target : i_jump_target; the branch wins if both are asserted.
- state <= S_REQ, and hold_buf is discarded.
- Any memory data returned in the redirect cycle is dropped.
- The memory is non-pipelined and tolerates an address change with no ready.

Flush and output rules:
- o_clearD = redirect | ~o_valid. With ~o_valid this inserts a bubble; the IF/ID hold still takes priority downstream when i_stall=1.
- o_add_pc = pc+1 always, modulo 2^ADDR_W; pc=30'h3FFF_FFFF gives o_add_pc=0 and the next PC wraps to 0.
- o_imem_addr = pc in all states.
- Latency: instruction at PC n is presented in the cycle ready arrives; it is in the IF/ID register at the next edge.

Test Plan:
- Reset then zero-wait memory returning rdata=32'h2000_0000+addr -> first req 1 cycle after reset release; addrs 0,1,2,3 on consecutive cycles; o_valid=1 each cycle; o_add_pc=1,2,3,4.
- Memory with 2 wait cycles at pc=5 -> req held, addr=5 for 3 cycles; o_valid=0 and o_clearD=1 for 2 cycles; then rdata presented and pc=6.
- Ready arrives at pc=8 with rdata=32'h8C01_0004 while i_stall=1 for 3 cycles -> S_HOLD, o_imem_req=0, o_instruct_dataF=32'h8C01_0004 held 3 cycles; pc=9 the cycle after stall drops.
- i_branch_taken=1, target=30'h40, during S_HOLD with i_stall=1 -> o_clearD=1 that cycle; next cycle addr=30'h40 in S_REQ; hold_buf discarded.
- i_branch_taken and i_jump in the same cycle (targets 30'h10, 30'h20) -> next addr=30'h10.
- Reset asserted mid-wait at pc=30'h3FFF_FFFF -> next cycle S_IDLE, addr=RESET_PC, o_valid=0. Separately, no reset at that pc with ready -> o_add_pc=0 and next addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency
// instruction memory and feeds the IF/ID register with hold/redirect.
module fetch_unit #(
    parameter int                 ADDR_W   = 30,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_instruct_dataF,
    output logic [ADDR_W-1:0] o_add_pc,
    output logic              o_valid,
    output logic              o_clearD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       hold_q, hold_d;
    logic              redirect;

    assign redirect    = i_branch_taken | i_jump;
    assign o_imem_addr = pc_q;
    assign o_add_pc    = pc_q + ADDR_W'(1);
    assign o_clearD    = redirect | ~o_valid;

    // State, PC and held-instruction registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state, PC update and IF/ID outputs; redirect overrides all
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        hold_d           = hold_q;
        o_imem_req       = 1'b0;
        o_valid          = 1'b0;
        o_instruct_dataF = '0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                o_imem_req = 1'b1;
                if (i_imem_ready) begin
                    o_valid          = 1'b1;
                    o_instruct_dataF = i_imem_rdata;
                    if (i_stall) begin
                        hold_d  = i_imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_HOLD: begin
                o_valid          = 1'b1;
                o_instruct_dataF = hold_q;
                if (!i_stall) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Taken branch beats jump; buffered instruction is discarded
        if (redirect) begin
            pc_d    = i_branch_taken ? i_branch_target : i_jump_target;
            state_d = S_REQ;
            hold_d  = '0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model
// checked every cycle plus hand-computed literal expectations.
module tb_fetch_unit;

    localparam int AW = 30;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          br;
    logic [AW-1:0] bt;
    logic          jmp;
    logic [AW-1:0] jt;
    logic          req;
    logic [AW-1:0] addr;
    logic          rdy;
    logic [31:0]   rdata;
    logic [31:0]   instr;
    logic [AW-1:0] add_pc;
    logic          valid;
    logic          clr;

    logic          ovr_en;
    logic [31:0]   ovr;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_W(AW), .RESET_PC(30'h0)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (bt),
        .i_jump          (jmp),
        .i_jump_target   (jt),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ready    (rdy),
        .i_imem_rdata    (rdata),
        .o_instruct_dataF(instr),
        .o_add_pc        (add_pc),
        .o_valid         (valid),
        .o_clearD        (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word at address a holds 0x2000_0000 + a unless overridden
    assign rdata = ovr_en ? ovr : (32'h2000_0000 + {2'b00, addr});

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: mode 0 = bubble, 1 = fetching, 2 = holding
    int            m_mode = 0;
    logic [AW-1:0] m_pc   = '0;
    logic [31:0]   m_hold = '0;
    bit            m_known = 0;

    always @(negedge clk) begin
        logic          e_req, e_val;
        logic [31:0]   e_ins, mem;
        mem   = ovr_en ? ovr : (32'h2000_0000 + {2'b00, m_pc});
        e_req = (m_mode == 1);
        e_val = (m_mode == 2) || (m_mode == 1 && rdy);
        e_ins = (m_mode == 2) ? m_hold :
                (m_mode == 1 && rdy) ? mem : 32'h0;
        if (m_known) begin
            chk("req",    {31'b0, req},   {31'b0, e_req});
            chk("valid",  {31'b0, valid}, {31'b0, e_val});
            chk("instr",  instr,          e_ins);
            chk("addr",   {2'b0, addr},   {2'b0, m_pc});
            chk("add_pc", {2'b0, add_pc}, {2'b0, m_pc + 30'd1});
            chk("clearD", {31'b0, clr},
                {31'b0, br | jmp | ~e_val});
        end
        if (!rst_n) begin
            m_known = 1;
            m_mode  = 0;
            m_pc    = '0;
            m_hold  = '0;
        end else if (br || jmp) begin
            m_pc   = br ? bt : jt;
            m_mode = 1;
            m_hold = '0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rdy && stall) begin
                m_hold = mem;
                m_mode = 2;
            end else if (rdy) begin
                m_pc = m_pc + 30'd1;
            end
        end else if (!stall) begin
            m_pc   = m_pc + 30'd1;
            m_mode = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    typedef struct packed {
        logic r;
        logic s;
    } vec_t;

    initial begin
        vec_t tbl [8];
        tbl[0] = '{r:1'b0, s:1'b0};
        tbl[1] = '{r:1'b1, s:1'b1};
        tbl[2] = '{r:1'b0, s:1'b1};
        tbl[3] = '{r:1'b1, s:1'b0};
        tbl[4] = '{r:1'b1, s:1'b1};
        tbl[5] = '{r:1'b1, s:1'b1};
        tbl[6] = '{r:1'b0, s:1'b0};
        tbl[7] = '{r:1'b1, s:1'b0};

        rst_n = 0; stall = 0; br = 0; bt = '0; jmp = 0; jt = '0;
        rdy = 0; ovr_en = 0; ovr = '0;
        tick();
        tick();

        // Idle bubble right after reset release
        rst_n = 1; rdy = 1;
        at_neg();
        chk("lit_idle_req",   {31'b0, req},   32'd0);
        chk("lit_idle_valid", {31'b0, valid}, 32'd0);
        chk("lit_idle_clr",   {31'b0, clr},   32'd1);
        chk("lit_idle_addpc", {2'b0, add_pc}, 32'd1);
        tick();

        // Zero-wait back-to-back fetch
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("lit_seq_addr",  {2'b0, addr},   i);
            chk("lit_seq_valid", {31'b0, valid}, 32'd1);
            chk("lit_seq_instr", instr, 32'h2000_0000 + i);
            chk("lit_seq_addpc", {2'b0, add_pc}, i + 1);
            tick();
        end
        tick();

        // Two wait states at pc=5
        rdy = 0;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("lit_wait_addr", {2'b0, addr}, 32'd5);
            chk("lit_wait_clr",  {31'b0, clr}, 32'd1);
            tick();
        end
        rdy = 1;
        at_neg();
        chk("lit_wait_instr", instr, 32'h2000_0005);
        tick();
        at_neg();
        chk("lit_after_wait", {2'b0, addr}, 32'd6);
        tick();
        tick();

        // Stall while ready at pc=8
        ovr_en = 1; ovr = 32'h8C01_0004; stall = 1;
        at_neg();
        chk("lit_st_addr", {2'b0, addr}, 32'd8);
        tick();
        ovr_en = 0;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("lit_hold_req",   {31'b0, req}, 32'd0);
            chk("lit_hold_instr", instr, 32'h8C01_0004);
            tick();
        end
        stall = 0;
        tick();
        at_neg();
        chk("lit_pc9", {2'b0, addr}, 32'd9);

        // Branch during hold with stall asserted
        stall = 1;
        tick();
        br = 1; bt = 30'h40;
        at_neg();
        chk("lit_br_clr", {31'b0, clr}, 32'd1);
        tick();
        br = 0; stall = 0;
        at_neg();
        chk("lit_br_addr", {2'b0, addr}, 32'h40);
        chk("lit_br_req",  {31'b0, req}, 32'd1);
        tick();

        // Branch and jump together: branch wins
        br = 1; bt = 30'h10; jmp = 1; jt = 30'h20;
        tick();
        br = 0; jmp = 0;
        at_neg();
        chk("lit_bj_addr", {2'b0, addr}, 32'h10);
        tick();

        // PC wrap at the top of the address space
        jmp = 1; jt = 30'h3FFF_FFFF; rdy = 0;
        tick();
        jmp = 0; rdy = 1;
        at_neg();
        chk("lit_wrap_addpc", {2'b0, add_pc}, 32'd0);
        tick();
        at_neg();
        chk("lit_wrap_addr", {2'b0, addr}, 32'd0);
        tick();

        // Reset mid-wait at the top address
        jmp = 1; rdy = 0;
        tick();
        jmp = 0; rst_n = 0;
        tick();
        rst_n = 1;
        at_neg();
        chk("lit_rst_addr",  {2'b0, addr},   32'd0);
        chk("lit_rst_valid", {31'b0, valid}, 32'd0);
        chk("lit_rst_req",   {31'b0, req},   32'd0);
        tick();

        // Mixed ready/stall patterns checked by the model
        foreach (tbl[i]) begin
            rdy = tbl[i].r; stall = tbl[i].s;
            tick();
        end
        stall = 0; rdy = 1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
